// File: rtl/fsm_counter_driver.sv
// Initiator-side controller for the run/count/done counter engine: queues tagged
// count jobs, launches them one at a time, and reports each completion or timeout.
module fsm_counter_driver #(
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 7,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [CNT_W-1:0] i_req_cnt,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic             o_run,
    output logic [CNT_W-1:0] o_num_cnt,
    input  logic             i_idle,
    input  logic             i_running,
    input  logic             i_done,
    output logic             o_cpl_valid,
    output logic [TAG_W-1:0] o_cpl_tag,
    output logic             o_cpl_err,
    output logic             o_busy,
    output logic [15:0]      o_cpl_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CPL,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CNT_W-1:0] r_mem_cnt [DEPTH];
    logic [TAG_W-1:0] r_mem_tag [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [TMR_W-1:0] r_timer;
    logic [CNT_W-1:0] r_num_cnt;
    logic [15:0]      r_cpl_count;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_head_cnt;
    logic [TAG_W-1:0] w_head_tag;
    logic             w_timeout;
    logic             w_unused_running;

    // The engine's running flag carries no information the done pulse does not.
    assign w_unused_running = i_running;

    assign w_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push     = i_req_valid && !w_full;
    assign w_pop      = (r_state == S_CPL) || (r_state == S_ERR);
    assign w_head_cnt = r_mem_cnt[r_rd_ptr];
    assign w_head_tag = r_mem_tag[r_rd_ptr];
    assign w_timeout  = (r_timer == TMR_W'(TIMEOUT - 1));

    // Job storage carries no reset; only pointers and count define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_cnt[r_wr_ptr] <= i_req_cnt;
            r_mem_tag[r_wr_ptr] <= i_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Zero-count jobs complete without touching the engine.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_head_cnt == '0) begin
                        w_next = S_CPL;
                    end else if (i_idle) begin
                        w_next = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (i_done) begin
                    w_next = S_CPL;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_CPL:   w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer <= '0;
        end else if (r_state == S_LAUNCH) begin
            r_timer <= '0;
        end else if (r_state == S_WAIT) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // Count is presented alongside the launch pulse and held while the engine runs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_num_cnt <= '0;
        end else if (r_state == S_IDLE && w_next == S_LAUNCH) begin
            r_num_cnt <= w_head_cnt;
        end else if (w_next == S_CPL || w_next == S_ERR) begin
            r_num_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cpl_count <= '0;
        end else if (r_state == S_CPL) begin
            r_cpl_count <= r_cpl_count + 16'd1;
        end
    end

    always_comb begin
        o_run       = 1'b0;
        o_cpl_valid = 1'b0;
        o_cpl_tag   = '0;
        o_cpl_err   = 1'b0;
        case (r_state)
            S_LAUNCH: o_run = 1'b1;
            S_CPL: begin
                o_cpl_valid = 1'b1;
                o_cpl_tag   = w_head_tag;
            end
            S_ERR: begin
                o_cpl_valid = 1'b1;
                o_cpl_tag   = w_head_tag;
                o_cpl_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_req_ready = !w_full;
    assign o_num_cnt   = r_num_cnt;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;
    assign o_cpl_count = r_cpl_count;

endmodule

// File: tb/tb_fsm_counter_driver.sv
// Directed bench for fsm_counter_driver: single-job vector table plus
// back-to-back, full-FIFO and reset-during-WAIT sequences against a small engine model.
module tb_fsm_counter_driver;

    localparam int DEPTH   = 4;
    localparam int CNT_W   = 7;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [CNT_W-1:0] i_req_cnt;
    logic [TAG_W-1:0] i_req_tag;
    logic             o_run;
    logic [CNT_W-1:0] o_num_cnt;
    logic             i_idle;
    logic             i_running;
    logic             i_done;
    logic             o_cpl_valid;
    logic [TAG_W-1:0] o_cpl_tag;
    logic             o_cpl_err;
    logic             o_busy;
    logic [15:0]      o_cpl_count;

    always #5 clk = ~clk;

    fsm_counter_driver #(
        .DEPTH(DEPTH), .CNT_W(CNT_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_cnt(i_req_cnt), .i_req_tag(i_req_tag),
        .o_run(o_run), .o_num_cnt(o_num_cnt),
        .i_idle(i_idle), .i_running(i_running), .i_done(i_done),
        .o_cpl_valid(o_cpl_valid), .o_cpl_tag(o_cpl_tag), .o_cpl_err(o_cpl_err),
        .o_busy(o_busy), .o_cpl_count(o_cpl_count)
    );

    // Engine model: o_run at L with count N -> running L+1..L+N, done at L+N+1.
    logic             e_run  = 1'b0;
    logic             e_done = 1'b0;
    logic [CNT_W-1:0] e_rem  = '0;
    logic             hang   = 1'b0;

    always @(posedge clk) begin
        if (!reset_n) begin
            e_run  <= 1'b0;
            e_done <= 1'b0;
            e_rem  <= '0;
        end else begin
            e_done <= 1'b0;
            if (o_run) begin
                e_run <= 1'b1;
                e_rem <= o_num_cnt;
            end else if (e_run) begin
                if (e_rem == 1) begin
                    e_run  <= 1'b0;
                    e_done <= 1'b1;
                end
                e_rem <= e_rem - 1'b1;
            end
        end
    end

    assign i_idle    = !e_run && !e_done;
    assign i_running = e_run;
    assign i_done    = e_done && !hang;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [TAG_W-1:0] tag;
        logic             hang;
        int               lat;   // push cycle -> o_cpl_valid cycle
        logic             err;
        int               runs;
    } vec_t;

    vec_t vecs [6];
    int   nchk  = 0;
    int   nfail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int idx);
        int          k;
        int          run_k;
        int          cpl_k;
        int          nrun;
        logic        bad_hold;
        logic        bad_idle;
        logic [15:0] cnt0;
        logic [TAG_W-1:0] got_tag;
        logic        got_err;
        cnt0     = o_cpl_count;
        run_k    = -1;
        cpl_k    = -1;
        nrun     = 0;
        bad_hold = 1'b0;
        bad_idle = 1'b0;
        got_tag  = '0;
        got_err  = 1'b0;
        hang     = v.hang;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_cnt   = v.cnt;
        i_req_tag   = v.tag;
        chk($sformatf("v%0d_ready", idx), o_req_ready, 1);
        @(negedge clk);
        i_req_valid = 1'b0;
        k = 1;
        while (cpl_k < 0 && k < 400) begin
            if (o_run) begin
                nrun++;
                run_k = k;
            end
            if (o_cpl_valid) begin
                cpl_k   = k;
                got_tag = o_cpl_tag;
                got_err = o_cpl_err;
                if (o_num_cnt !== '0) bad_hold = 1'b1;
            end else begin
                if (run_k >= 0 && o_num_cnt !== v.cnt) bad_hold = 1'b1;
                if (o_cpl_tag !== '0 || o_cpl_err !== 1'b0) bad_idle = 1'b1;
            end
            if (cpl_k < 0) begin
                @(negedge clk);
                k++;
            end
        end
        chk($sformatf("v%0d_latency", idx), cpl_k, v.lat);
        chk($sformatf("v%0d_tag", idx), got_tag, v.tag);
        chk($sformatf("v%0d_err", idx), got_err, v.err);
        chk($sformatf("v%0d_runs", idx), nrun, v.runs);
        chk($sformatf("v%0d_num_cnt_hold", idx), bad_hold, 0);
        chk($sformatf("v%0d_cpl_fields_idle", idx), bad_idle, 0);
        @(negedge clk);
        hang = 1'b0;
        chk($sformatf("v%0d_cpl_count", idx), o_cpl_count, cnt0 + (v.err ? 16'd0 : 16'd1));
        chk($sformatf("v%0d_busy_after", idx), o_busy, 0);
        chk($sformatf("v%0d_cpl_valid_one_cycle", idx), o_cpl_valid, 0);
    endtask

    task automatic back_to_back();
        int          ncpl;
        logic        pushed5;
        logic        push_after_cpl;
        logic [15:0] cnt0;
        ncpl           = 0;
        pushed5        = 1'b0;
        push_after_cpl = 1'b0;
        cnt0           = o_cpl_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_req_valid = 1'b1;
            i_req_cnt   = CNT_W'(i + 2);
            i_req_tag   = TAG_W'(i);
        end
        @(negedge clk);
        i_req_cnt = 7'd1;
        i_req_tag = 4'd4;
        chk("b2b_ready_when_full", o_req_ready, 0);
        for (int c = 0; c < 200 && ncpl < 5; c++) begin
            if (o_cpl_valid) begin
                if (ncpl == 0) chk("b2b_ready_at_first_pop", o_req_ready, 0);
                chk($sformatf("b2b_tag%0d", ncpl), o_cpl_tag, ncpl);
                chk($sformatf("b2b_err%0d", ncpl), o_cpl_err, 0);
                ncpl++;
            end
            if (i_req_valid && o_req_ready && !pushed5) begin
                pushed5        = 1'b1;
                push_after_cpl = (ncpl > 0);
            end
            @(negedge clk);
            if (pushed5) i_req_valid = 1'b0;
        end
        chk("b2b_completions", ncpl, 5);
        chk("b2b_fifth_pushed", pushed5, 1);
        chk("b2b_fifth_after_pop", push_after_cpl, 1);
        @(negedge clk);
        chk("b2b_cpl_count", o_cpl_count, cnt0 + 16'd5);
    endtask

    task automatic reset_mid_wait();
        int   k;
        int   nbad;
        logic seen_run;
        seen_run = 1'b0;
        nbad     = 0;
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_cnt   = 7'd20;
        i_req_tag   = 4'd1;
        @(negedge clk);
        i_req_tag   = 4'd2;
        @(negedge clk);
        i_req_valid = 1'b0;
        k = 0;
        while (!seen_run && k < 20) begin
            if (o_run) seen_run = 1'b1;
            @(negedge clk);
            k++;
        end
        chk("rst_job_launched", seen_run, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_ready", o_req_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_run", o_run, 0);
        chk("rst_num_cnt", o_num_cnt, 0);
        chk("rst_cpl_valid", o_cpl_valid, 0);
        chk("rst_cpl_tag", o_cpl_tag, 0);
        chk("rst_cpl_err", o_cpl_err, 0);
        chk("rst_cpl_count", o_cpl_count, 0);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (o_cpl_valid || o_run || o_busy) nbad++;
        end
        chk("rst_jobs_discarded", nbad, 0);
    endtask

    initial begin
        vecs[0] = '{cnt: 7'd5,   tag: 4'd3,  hang: 1'b0, lat: 9,           err: 1'b0, runs: 1};
        vecs[1] = '{cnt: 7'd0,   tag: 4'd9,  hang: 1'b0, lat: 2,           err: 1'b0, runs: 0};
        vecs[2] = '{cnt: 7'd1,   tag: 4'd7,  hang: 1'b0, lat: 5,           err: 1'b0, runs: 1};
        vecs[3] = '{cnt: 7'd127, tag: 4'd15, hang: 1'b0, lat: 131,         err: 1'b0, runs: 1};
        vecs[4] = '{cnt: 7'd10,  tag: 4'd5,  hang: 1'b1, lat: TIMEOUT + 3, err: 1'b1, runs: 1};
        vecs[5] = '{cnt: 7'd3,   tag: 4'd1,  hang: 1'b0, lat: 7,           err: 1'b0, runs: 1};

        reset_n     = 1'b0;
        i_req_valid = 1'b0;
        i_req_cnt   = '0;
        i_req_tag   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", o_req_ready, 1);
        chk("reset_run", o_run, 0);
        chk("reset_num_cnt", o_num_cnt, 0);
        chk("reset_cpl_valid", o_cpl_valid, 0);
        chk("reset_cpl_tag", o_cpl_tag, 0);
        chk("reset_cpl_err", o_cpl_err, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_cpl_count", o_cpl_count, 0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i], i);
        end

        back_to_back();
        reset_mid_wait();

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, limit %0d ns", 500000);
        $fatal(1, "timeout");
    end

endmodule
